// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM encoding,
// default latencies and op-class helpers. MDU_MADD_EN enables the accumulate ops.
package md_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MTHI  = 4'd4,
        OP_MTLO  = 4'd5,
        OP_MADD  = 4'd6,
        OP_MADDU = 4'd7,
        OP_MSUB  = 4'd8,
        OP_MSUBU = 4'd9
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;
    localparam int CNT_W        = 5;

    function automatic logic is_mult_class(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_class(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_multi_op(input logic [3:0] op);
        return is_mult_class(op) || is_div_class(op);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit result generator for the sequencer ({HI,LO} image).
// Accumulate ops are only decoded when MDU_MADD_EN is defined.
module md_arith
    import md_sequencer_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result64
);

    logic signed [63:0] a_s;
    logic signed [63:0] b_s;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign a_s    = {{32{a[31]}}, a};
    assign b_s    = {{32{b[31]}}, b};
    assign prod_s = a_s * b_s;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Returns {remainder, quotient}; zero divisor and INT_MIN/-1 are defined cases.
    function automatic logic [63:0] div_signed(input logic [31:0] n, input logic [31:0] d);
        logic signed [31:0] ns;
        logic signed [31:0] ds;
        logic signed [31:0] q;
        logic signed [31:0] r;
        ns = n;
        ds = (d == 32'd0) ? 32'sd1 : d;
        q  = ns / ds;
        r  = ns % ds;
        if (d == 32'd0)
            return {n, 32'hFFFF_FFFF};
        else if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF)
            return {32'd0, 32'h8000_0000};
        else
            return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] ds;
        ds = (d == 32'd0) ? 32'd1 : d;
        if (d == 32'd0)
            return {n, 32'hFFFF_FFFF};
        else
            return {n % ds, n / ds};
    endfunction

    always_comb begin
        result64 = {hi, lo};
        case (op)
            OP_MULT:  result64 = prod_s;
            OP_MULTU: result64 = prod_u;
            OP_DIV:   result64 = div_signed(a, b);
            OP_DIVU:  result64 = div_unsigned(a, b);
`ifdef MDU_MADD_EN
            OP_MADD:  result64 = {hi, lo} + prod_s;
            OP_MADDU: result64 = {hi, lo} + prod_u;
            OP_MSUB:  result64 = {hi, lo} - prod_s;
            OP_MSUBU: result64 = {hi, lo} - prod_u;
`endif
            default:  result64 = {hi, lo};
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle MDU sequencer: owns HI/LO, holds a pending result for LAT cycles
// and raises stall_req to the hazard unit. MDU_MADD_EN enables MADD/MSUB ops.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   lat_sel;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic [63:0]        result64;
    logic               accept_multi;
    logic               accept_mt;
    logic               last_cycle;

    md_arith u_arith (
        .a        (a),
        .b        (b),
        .op       (op),
        .hi       (hi),
        .lo       (lo),
        .result64 (result64)
    );

    assign accept_multi = (state_q == ST_IDLE) && start && is_multi_op(op);
    assign accept_mt    = (state_q == ST_IDLE) && start && (op == OP_MTHI || op == OP_MTLO);
    assign last_cycle   = (state_q == ST_RUN) && (cnt == CNT_W'(1));
    assign lat_sel      = is_div_class(op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_multi) state_d = ST_RUN;
            ST_RUN:  if (cnt == CNT_W'(1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_RUN);
        stall_req = ~reset & d_is_md & (busy | (start & is_multi_op(op)));
    end

    // Counter, pending result and architectural HI/LO; starts during RUN fall through untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= last_cycle;
            if (accept_multi) begin
                pend_hi <= result64[63:32];
                pend_lo <= result64[31:0];
                cnt     <= lat_sel;
            end else if (accept_mt) begin
                if (op == OP_MTHI)
                    hi <= a;
                else
                    lo <= a;
            end else if (state_q == ST_RUN) begin
                cnt <= cnt - CNT_W'(1);
                if (last_cycle) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: directed ops push expected {HI,LO} images,
// a negedge monitor pops one per done pulse. MDU_MADD_EN selects the accumulate case.
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_is_md;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          tests      = 0;
    int          fails      = 0;
    int          done_count = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    always #5 clk = ~clk;

    md_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .d_is_md   (d_is_md),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h, want no pulse", hi, lo);
            end else begin
                check("result", {hi, lo}, sb.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mt(input logic [3:0] o, input logic [31:0] x);
        start = 1'b1; op = o; a = x;
        tick;
        start = 1'b0;
        if (o == 4'd4) exp_hi = x; else exp_lo = x;
    endtask

    task automatic run_multi(input string name, input logic [3:0] o, input logic [31:0] x,
                             input logic [31:0] y, input int lat, input logic [63:0] exp);
        int n;
        int d0;
        n  = 0;
        d0 = done_count;
        sb.push_back(exp);
        start = 1'b1; op = o; a = x; b = y;
        tick;
        start = 1'b0;
        while (busy && n < 64) begin
            n++;
            tick;
        end
        check({name, "_busy_cycles"}, 64'(n), 64'(lat));
        tick;
        check({name, "_done_once"}, 64'(done_count), 64'(d0 + 1));
        exp_hi = exp[63:32];
        exp_lo = exp[31:0];
    endtask

    initial begin
        int n;
        int s;
        int d0;
        reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; d_is_md = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        d_is_md = 1'b0;

        run_multi("mult_neg",   4'd0, 32'hFFFF_FFFD, 32'd7,         5,  64'hFFFF_FFFF_FFFF_FFEB);
        run_multi("div_neg",    4'd2, 32'hFFFF_FFF9, 32'd2,         10, 64'hFFFF_FFFF_FFFF_FFFD);
        run_multi("divu_zero",  4'd3, 32'd7,         32'd0,         10, 64'h0000_0007_FFFF_FFFF);
        run_multi("div_ovf",    4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000);
        run_multi("div_negdiv", 4'd2, 32'd7,         32'hFFFF_FFFE, 10, 64'h0000_0001_FFFF_FFFD);
        run_multi("div_zero_s", 4'd2, 32'hFFFF_FFFB, 32'd0,         10, 64'hFFFF_FFFB_FFFF_FFFF);
        run_multi("divu_big",   4'd3, 32'hFFFF_FFFF, 32'd16,        10, 64'h0000_000F_0FFF_FFFF);
        run_multi("mult_min",   4'd0, 32'h8000_0000, 32'h8000_0000, 5,  64'h4000_0000_0000_0000);

        d0 = done_count;
        mt(4'd4, 32'h1234);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_hilo", {hi, lo}, {32'h1234, exp_lo});
        mt(4'd5, 32'hABCD);
        check("mtlo_hilo", {hi, lo}, {32'h1234, 32'hABCD});
        tick;
        check("mt_no_done", 64'(done_count), 64'(d0));

        // MULTU with the D stage holding an MDU op; two starts arrive mid-run
        d0 = done_count;
        sb.push_back(64'h0000_0001_FFFF_FFFE);
        d_is_md = 1'b1;
        start = 1'b1; op = 4'd1; a = 32'hFFFF_FFFF; b = 32'd2;
        #1;
        check("stall_start", 64'(stall_req), 64'd1);
        tick;
        start = 1'b0;
        n = 0;
        s = 0;
        while (busy && n < 64) begin
            n++;
            if (stall_req) s++;
            if (n == 2) begin
                start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
            end else if (n == 3) begin
                start = 1'b1; op = 4'd5; a = 32'hDEAD;
            end else begin
                start = 1'b0;
            end
            if (n == 4) check("run_hold", {hi, lo}, {exp_hi, exp_lo});
            tick;
        end
        start = 1'b0;
        check("multu_busy_cycles", 64'(n), 64'd5);
        check("multu_stall_cycles", 64'(s), 64'd5);
        check("stall_after", 64'(stall_req), 64'd0);
        tick;
        check("multu_done_once", 64'(done_count), 64'(d0 + 1));
        exp_hi = 32'd1;
        exp_lo = 32'hFFFF_FFFE;
        d_is_md = 1'b0;

        start = 1'b1; op = 4'hF; a = 32'd5; b = 32'd5;
        tick;
        start = 1'b0;
        check("undef_busy", 64'(busy), 64'd0);
        tick;
        check("undef_hilo", {hi, lo}, {exp_hi, exp_lo});

`ifdef MDU_MADD_EN
        mt(4'd4, 32'd0);
        mt(4'd5, 32'hFFFF_FFFF);
        run_multi("maddu", 4'd7, 32'd1, 32'd1, 5, 64'h0000_0001_0000_0000);
`else
        start = 1'b1; op = 4'd6; a = 32'd1; b = 32'd1;
        tick;
        start = 1'b0;
        check("madd_off_busy", 64'(busy), 64'd0);
        tick;
        check("madd_off_hilo", {hi, lo}, {exp_hi, exp_lo});
`endif

        // reset lands in the third busy cycle of a DIV
        d0 = done_count;
        start = 1'b1; op = 4'd2; a = 32'd64; b = 32'd3;
        tick;
        start = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rst_run_busy", 64'(busy), 64'd0);
        check("rst_run_hilo", {hi, lo}, 64'd0);
        repeat (12) tick;
        check("rst_run_no_done", 64'(done_count), 64'(d0));

        mt(4'd4, 32'h55);
        reset = 1'b1; start = 1'b1; op = 4'd0; a = 32'd3; b = 32'd3;
        tick;
        reset = 1'b0; start = 1'b0;
        check("rst_prio_busy", 64'(busy), 64'd0);
        check("rst_prio_hilo", {hi, lo}, 64'd0);
        repeat (7) tick;
        check("rst_prio_no_done", 64'(done_count), 64'(d0));

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 time units, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 Parameter MULT_LAT, default 5, busy cycles for multiply-class ops (legal range 1..31).
REQ-002 Parameter DIV_LAT, default 10, busy cycles for divide-class ops (legal range 1..31).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: E-stage issues an MDU operation this cycle.
REQ-006 Port op, input, 4: operation code, valid when start=1.
REQ-007 Port a, input, 32: forwarded rs operand.
REQ-008 Port b, input, 32: forwarded rt operand.
REQ-009 Port d_is_md, input, 1: the D-stage instruction is an MDU-class op (mult/div/mthi/mtlo/mfhi/mflo/madd/msub).
REQ-010 Port busy, output, 1: a multi-cycle operation is in progress.
REQ-011 Port stall_req, output, 1: request to the hazard unit to hold F/D and clear E.
REQ-012 Port done, output, 1: one-cycle pulse in the cycle after HI/LO commit.
REQ-013 Ports hi and lo, output, 32 each: architectural HI/LO registers.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-015 In IDLE, start with MULT/MULTU/DIV/DIVU SHALL latch the result into pending registers, load counter = LAT, and enter RUN.
REQ-016 busy SHALL be 1 for exactly LAT cycles, starting the cycle after the start cycle.
REQ-017 In RUN the counter SHALL decrement each cycle; at counter==1, pending SHALL be written to HI/LO on that edge and the FSM SHALL return to IDLE.
REQ-018 In IDLE, start with MTHI/MTLO SHALL write a to hi/lo on the same edge, with no busy and no done.
REQ-019 start while busy=1 SHALL be ignored; state, counter, pending, HI and LO stay unchanged.
REQ-020 stall_req SHALL equal d_is_md & (busy | (start & op is multi-cycle)).
REQ-021 MULT SHALL produce a signed 64-bit product and MULTU an unsigned one; {HI,LO} = product.
REQ-022 DIV/DIVU: LO = quotient (truncated toward zero), HI = remainder (takes the dividend's sign).
REQ-023 Divide by zero SHALL give LO = 32'hFFFF_FFFF and HI = a.
REQ-024 Signed 32'h8000_0000 / -1 SHALL give LO = 32'h8000_0000 and HI = 0.
REQ-025 Undefined op codes with start=1 SHALL be ignored.

Reset
REQ-026 reset SHALL force IDLE, counter = 0, hi = 0, lo = 0, busy = 0, done = 0 and stall_req = 0, and clear the pending registers.
REQ-027 reset during RUN SHALL discard the pending result; HI/LO read 0 the next cycle.
REQ-028 reset SHALL take priority over a simultaneous start.

Configuration
REQ-029 With macro MDU_MADD_EN defined, MADD/MADDU/MSUB/MSUBU SHALL be multiply-class ops.
- Result = {HI,LO} +/- product, using the HI/LO values at the start edge.
- 64-bit wrap-around.
REQ-030 Without MDU_MADD_EN, those four codes SHALL be treated as undefined (REQ-025).

Structure
REQ-031 A shared package SHALL hold:
- op codes MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MADD=6, MADDU=7, MSUB=8, MSUBU=9;
- FSM state encoding;
- default latency constants.
REQ-032 Combinational arithmetic SHALL live in one sub-module, md_arith (inputs a, b, op, hi, lo; output result64); sequencing stays in md_sequencer.

Verification
REQ-033 MULT a=-3, b=7 -> busy high 5 cycles; then {hi,lo} = 32'hFFFF_FFFF / 32'hFFFF_FFEB; done pulses once.
REQ-034 DIV a=-7, b=2 -> busy 10 cycles; lo = 32'hFFFF_FFFD, hi = 32'hFFFF_FFFF. DIVU a=7, b=0 -> lo = 32'hFFFF_FFFF, hi = 7.
REQ-035 MULTU starts with d_is_md=1 -> stall_req=1 in the start cycle and in all 5 busy cycles, then 0. A second start mid-run is ignored.
REQ-036 MTHI a=32'h1234 while idle -> hi = 32'h1234 the next cycle; busy stays 0.
REQ-037 reset asserted in the 3rd busy cycle of DIV -> next cycle busy=0, hi=lo=0, and no done pulse.
REQ-038 With MDU_MADD_EN: hi=0, lo=32'hFFFF_FFFF, then MADDU a=1, b=1 -> hi=1, lo=0.
